// File: rtl/add_sub_seq.sv
// add_sub_seq: multi-cycle signed add/sub, one CHUNK_WIDTH slice per clock
// through a registered carry chain, with optional saturation and handshakes.
module add_sub_seq #(
   parameter int DATA_WIDTH  = 16,
   parameter int CHUNK_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic [3:0]            FuncCode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] C,
   output logic                  OverflowFlag,
   output logic                  CarryFlag
);

   localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
   localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
   localparam logic [DATA_WIDTH-1:0] CHUNK_MASK =
      DATA_WIDTH'({CHUNK_WIDTH{1'b1}});
   localparam logic [DATA_WIDTH-1:0] SAT_MAX =
      {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SAT_MIN =
      {1'b1, {(DATA_WIDTH-1){1'b0}}};

   if ((DATA_WIDTH % CHUNK_WIDTH) != 0) begin : gBadWidth
      $error("DATA_WIDTH must be a multiple of CHUNK_WIDTH");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t state, stateNext;

   logic [DATA_WIDTH-1:0]  aReg;
   logic [DATA_WIDTH-1:0]  bOp;
   logic                   carry;
   logic                   aMsb;
   logic                   bMsb;
   logic [3:0]             func;
   logic [IDX_W-1:0]       idx;

   logic                   accept;
   logic                   lastChunk;
   logic                   validOp;
   logic                   subOp;
   logic                   satOp;
   logic                   rawOvf;
   int unsigned            shift;
   logic [CHUNK_WIDTH-1:0] aChunk;
   logic [CHUNK_WIDTH-1:0] bChunk;
   logic [CHUNK_WIDTH:0]   chunkSum;
   logic [DATA_WIDTH-1:0]  raw;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && (state == IDLE);
   assign lastChunk = (state == BUSY) && (idx == LAST_IDX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (in_valid) stateNext = BUSY;
         BUSY:    if (lastChunk) stateNext = DONE;
         DONE:    if (out_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      validOp = 1'b0;
      subOp   = 1'b0;
      satOp   = 1'b0;
      unique case (func)
         4'b0000: validOp = 1'b1;
         4'b0001: begin validOp = 1'b1; subOp = 1'b1; end
         4'b0010: begin validOp = 1'b1; satOp = 1'b1; end
         4'b0011: begin
            validOp = 1'b1;
            subOp   = 1'b1;
            satOp   = 1'b1;
         end
         default: validOp = 1'b0;
      endcase
   end

   // raw is C with the current slice merged in; on the last slice it is R
   always_comb begin
      shift    = 32'(idx) * CHUNK_WIDTH;
      aChunk   = CHUNK_WIDTH'(aReg >> shift);
      bChunk   = CHUNK_WIDTH'(bOp >> shift);
      chunkSum = {1'b0, aChunk} + {1'b0, bChunk}
               + (CHUNK_WIDTH+1)'(carry);
      raw      = (C & ~(CHUNK_MASK << shift))
               | (DATA_WIDTH'(chunkSum[CHUNK_WIDTH-1:0]) << shift);
      if (subOp)
         rawOvf = (aMsb != bMsb) && (raw[DATA_WIDTH-1] != aMsb);
      else
         rawOvf = (aMsb == bMsb) && (raw[DATA_WIDTH-1] != aMsb);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         aReg         <= '0;
         bOp          <= '0;
         carry        <= 1'b0;
         aMsb         <= 1'b0;
         bMsb         <= 1'b0;
         func         <= '0;
         idx          <= '0;
         C            <= '0;
         OverflowFlag <= 1'b0;
         CarryFlag    <= 1'b0;
      end else if (accept) begin
         aReg  <= A;
         bOp   <= FuncCode[0] ? ~B : B;
         carry <= FuncCode[0];
         func  <= FuncCode;
         aMsb  <= A[DATA_WIDTH-1];
         bMsb  <= B[DATA_WIDTH-1];
         idx   <= '0;
      end else if (state == BUSY) begin
         carry <= chunkSum[CHUNK_WIDTH];
         idx   <= idx + 1'b1;
         if (!lastChunk) begin
            C <= raw;
         end else if (!validOp) begin
            C            <= '0;
            OverflowFlag <= 1'b0;
            CarryFlag    <= 1'b0;
         end else begin
            OverflowFlag <= rawOvf;
            CarryFlag    <= chunkSum[CHUNK_WIDTH];
            if (satOp && rawOvf) C <= aMsb ? SAT_MIN : SAT_MAX;
            else                 C <= raw;
         end
      end
   end

endmodule

// File: doc/add_sub_seq.md
# add_sub_seq

Parametrised, multi-cycle signed add/subtract unit: the next generation of the lab ALU's add/sub datapath. Operands are processed in `CHUNK_WIDTH`-bit slices, one slice per clock, through a registered carry chain, with optional saturating modes and valid/ready handshakes on both sides. It sits between the ALU operand registers and the result writeback, where a wide combinational adder would limit clock rate.

## Interface
- `DATA_WIDTH`, default 16: operand and result width in bits.
- `CHUNK_WIDTH`, default 4: bits processed per cycle. `DATA_WIDTH` must be a multiple of `CHUNK_WIDTH`. `NUM_CHUNKS = DATA_WIDTH/CHUNK_WIDTH`.

Ports (clock and reset first):
- `clk` input 1: single clock; all state updates on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands and FuncCode valid.
- `in_ready` output 1: unit can accept; equals (state == IDLE).
- `A` input DATA_WIDTH: operand A, two's complement.
- `B` input DATA_WIDTH: operand B, two's complement.
- `FuncCode` input 4: 0000 add, 0001 sub, 0010 saturating add, 0011 saturating sub, others invalid.
- `out_valid` output 1: C and flags valid; equals (state == DONE).
- `out_ready` input 1: consumer takes result.
- `C` output DATA_WIDTH: result register.
- `OverflowFlag` output 1: signed overflow of the unsaturated result.
- `CarryFlag` output 1: carry out of the MSB. For sub this is the not-borrow flag (1 when A ≥ B unsigned).

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: on `in_valid && in_ready`, capture A, B-operand (B for add, ~B for sub), carry-in (0 add, 1 sub), FuncCode, and the MSBs of A and B. Clear chunk index. Go to BUSY.
- BUSY: each cycle, chunk i of the result = chunk i of A + chunk i of B-operand + carry register. Write it into C[i*CHUNK_WIDTH +: CHUNK_WIDTH]. Update the carry register and increment i. On the cycle processing chunk NUM_CHUNKS-1, go to DONE.
- DONE entry (same edge as the last chunk): compute flags from the full raw result R.
  - Add overflow: A.msb == B.msb && R.msb != A.msb.
  - Sub overflow: A.msb != B.msb && R.msb != A.msb.
  - CarryFlag = final carry out.
  - Saturating modes with overflow: C = A.msb ? 100…0 : 011…1. OverflowFlag stays 1.
  - Non-saturating modes: C = R (wraps modulo 2^DATA_WIDTH).
- Invalid FuncCode: the operation is accepted and takes the same latency. Result is C = 0, OverflowFlag = 0, CarryFlag = 0.
- DONE: C and both flags are held stable while `out_valid && !out_ready`. On `out_valid && out_ready`, go to IDLE. C and flags keep their value in IDLE until the next operation overwrites them chunk by chunk.
- `in_valid` is ignored outside IDLE. No operand is captured in BUSY or DONE.
- `NUM_CHUNKS == 1` is legal: BUSY lasts one cycle.

## Timing
- Reset (`reset_n` low, asynchronous, any state):
  - State becomes IDLE; C, OverflowFlag, CarryFlag, carry register and chunk index become 0.
  - `out_valid` = 0 and `in_ready` = 1 while in reset. No capture occurs while reset is asserted.
  - Any in-flight operation is discarded.
- Latency: acceptance edge at cycle 0 → `out_valid` high after edge NUM_CHUNKS (4 cycles for defaults).
- Throughput: one operation per NUM_CHUNKS+2 cycles with `out_ready` held high (accept, NUM_CHUNKS busy, one DONE handshake cycle, return to IDLE).
- `in_ready` and `out_valid` are never high in the same cycle.
- No combinational path from `in_valid` to `out_valid`, or from `out_ready` to `in_ready`, within a cycle. Both are functions of registered state only.

## Test plan
Defaults 16/4 unless stated.
- Add 0x7FFF + 0x0001, FuncCode 0000 → out_valid 4 cycles after accept, C=0x8000, OverflowFlag=1, CarryFlag=0.
- Add 0xFFFF + 0x0001, FuncCode 0000 → carry ripples through all chunks: C=0x0000, OverflowFlag=0, CarryFlag=1. Repeat with CHUNK_WIDTH=16 and CHUNK_WIDTH=1 → same result, latency 1 and 16 respectively.
- Saturating sub 0x8000 − 0x0001, FuncCode 0011 → C=0x8000, OverflowFlag=1, CarryFlag=1. Saturating add 0x7000 + 0x7000, FuncCode 0010 → C=0x7FFF, OverflowFlag=1.
- Backpressure: complete 0x0003 − 0x0005 (expect C=0xFFFE, OverflowFlag=0, CarryFlag=0). Hold out_ready=0 for 5 cycles while driving in_valid=1 with new operands → C and flags stable, in_ready=0, new operands not captured. Raise out_ready → IDLE next cycle.
- FuncCode 0101 with A=0x1234, B=0x4321 → after 4 cycles C=0x0000, both flags 0.
- Pull reset_n low asynchronously mid-BUSY after 2 chunks → immediately out_valid=0, C=0, in_ready=1. After release, 0x0010 + 0x0020 add → C=0x0030 with normal latency.
